conv_mac_array: RTL and testbench
=================================

// Module: conv_mac_array
// PURPOSE
//  Parametrised multiply-accumulate engine for conv layers. Replaces the single-lane vector_muladd with CPF input channels x KPF output
//  kernels per beat, runtime requant shift, runtime ReLU, round/saturate and saturation statistics. Sits behind the layer controller:
//  row-memory data, weight-buffer words and bias words arrive together per beat; one result vector is emitted per packet (op_din_eop).
// PARAMETERS
//  CPF        4   input channels consumed per beat
//  KPF        2   output kernels (lanes) computed in parallel
//  DIN_DW     16  signed data width per channel
//  WW         8   signed weight width
//  BIAS_DW    8   signed bias width
//  BIAS_SHIFT 0   left shift aligning bias to accumulator Q point
//  ACC_WIDTH  40  signed accumulator width per lane
//  DOUT_DW    16  signed output width per lane
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    asynchronous reset, active-low
//  op_din_en    in   1                    beat valid
//  op_din_eop   in   1                    last beat of packet (qualified by op_din_en)
//  op_din       in   CPF*DIN_DW           data, channel c at [c*DIN_DW +: DIN_DW]
//  op_weight    in   KPF*CPF*WW           weights, lane k chan c at [(k*CPF+c)*WW +: WW]
//  op_bias      in   KPF*BIAS_DW          bias per lane, sampled on first beat of packet
//  cfg_shift    in   6                    arithmetic right shift for requant, sampled on first beat
//  cfg_relu     in   1                    1 = clamp negatives to 0, sampled on first beat
//  op_dout_en   out  1                    one-cycle result strobe
//  op_dout      out  KPF*DOUT_DW          results, lane k at [k*DOUT_DW +: DOUT_DW]
//  busy         out  1                    packet in flight (first beat seen, result not yet emitted)
//  sat_cnt      out  16                   count of saturated lane results, sticks at 16'hFFFF
// BEHAVIOUR
//  - Reset (rst=0, async): op_dout_en=0, op_dout=0, busy=0, sat_cnt=0, all pipe valids/accumulators cleared, next beat is "first".
//  - Pipeline, all stages registered:
//    S1 register prod[k][c]=din[c]*w[k][c] (signed, DIN_DW+WW bits), carry en/eop/first/cfg/bias.
//    S2 sum[k]=sign-extended sum over c of prod[k][c] (ACC_WIDTH).
//    S3 acc[k] = first ? sum[k] + (sext(bias[k])<<BIAS_SHIFT) : acc[k] + sum[k]. Only on valid; bubbles hold acc.
//    S4 on valid eop: r = (shift==0) ? acc : (acc + (1<<(shift-1))) >>> shift; if relu and r<0 then r=0;
//       saturate to [-2^(DOUT_DW-1), 2^(DOUT_DW-1)-1]; register op_dout, pulse op_dout_en.
//  - Latency: eop beat at cycle T -> op_dout_en high at T+4 for exactly one cycle; op_dout holds until next result.
//  - first flag: set by reset and by any accepted eop beat; cleared by any accepted non-eop beat. Single-beat packet
//    (first and eop same beat) is legal. Back-to-back packets with no gap are legal: accumulation restarts the beat after eop
//    without loss; one result per cycle max throughput.
//  - op_din_eop without op_din_en is ignored. No backpressure: consumer must accept every op_dout_en.
//  - cfg_shift, cfg_relu, op_bias captured only on first beat; changes mid-packet have no effect on that packet.
//    cfg_shift >= ACC_WIDTH is treated as ACC_WIDTH-1.
//  - Accumulator wraps two's complement; no overflow detection (sizing is the integrator's job).
//  - sat_cnt += number of lanes clipped by saturation on each result (ReLU clamp is not saturation); saturates at 16'hFFFF.
//  - busy: 1 from first accepted beat until cycle of op_dout_en of its eop; stays 1 across back-to-back packets.
//  - Reset mid-packet: partial accumulation and in-flight results discarded, no op_dout_en emitted for them.
// TESTING (defaults, BIAS_SHIFT=0)
//  1 single beat din={4,3,2,1}(c3..c0), lane0 w all 1, lane1 w all -1, bias {5,0}, shift 0 -> 4 cycles later dout lane0=10, lane1=-5.
//  2 3-beat packet din=1s, w=2 all, bias 0, 2 idle cycles between beats -> lane outputs 24, one strobe, busy high throughout.
//  3 din all 32767, w all 127, 4 beats, shift 0 -> both lanes 32767, sat_cnt=2; negative mirror -> -32768, sat_cnt=4.
//  4 acc=-3 (din {-3,0,0,0}, w 1), shift 1, relu 0 -> -1; same with relu 1 -> 0, sat_cnt unchanged.
//  5 8 back-to-back single-beat packets, din[0]=n, w=1, bias 0 -> 8 consecutive strobes with values 0..7, no cross-contamination.
//  6 assert rst=0 after 2 beats of a 4-beat packet, release, send 1-beat packet din[0]=7,w=1 -> only one strobe, value 7.

Source files
------------

// File: rtl/conv_mac_array_if.sv
// ============================================================================
// conv_mac_array_if : beat/result bus between layer controller and MAC array
// Rev 1.0
// ============================================================================
`default_nettype none

interface conv_mac_array_if #(
  parameter int CPF     = 4,
  parameter int KPF     = 2,
  parameter int DIN_DW  = 16,
  parameter int WW      = 8,
  parameter int BIAS_DW = 8,
  parameter int DOUT_DW = 16
);
  logic                     op_din_en;
  logic                     op_din_eop;
  logic [CPF*DIN_DW-1:0]    op_din;
  logic [KPF*CPF*WW-1:0]    op_weight;
  logic [KPF*BIAS_DW-1:0]   op_bias;
  logic [5:0]               cfg_shift;
  logic                     cfg_relu;
  logic                     op_dout_en;
  logic [KPF*DOUT_DW-1:0]   op_dout;
  logic                     busy;
  logic [15:0]              sat_cnt;

  modport master (
    output op_din_en, op_din_eop, op_din, op_weight, op_bias, cfg_shift, cfg_relu,
    input  op_dout_en, op_dout, busy, sat_cnt
  );

  modport slave (
    input  op_din_en, op_din_eop, op_din, op_weight, op_bias, cfg_shift, cfg_relu,
    output op_dout_en, op_dout, busy, sat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/conv_mac_array.sv
// ============================================================================
// conv_mac_array : CPF x KPF multiply-accumulate engine with requant/ReLU/sat
// Rev 1.0
// ============================================================================
`default_nettype none

module conv_mac_array #(
  parameter int CPF        = 4,
  parameter int KPF        = 2,
  parameter int DIN_DW     = 16,
  parameter int WW         = 8,
  parameter int BIAS_DW    = 8,
  parameter int BIAS_SHIFT = 0,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_DW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  conv_mac_array_if.slave bus
);

  localparam int                      c_pw        = DIN_DW + WW;
  localparam logic [5:0]              c_shift_max = 6'(ACC_WIDTH - 1);
  localparam logic signed [ACC_WIDTH:0] c_max =
    {{(ACC_WIDTH + 2 - DOUT_DW){1'b0}}, {(DOUT_DW - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] c_min =
    {{(ACC_WIDTH + 2 - DOUT_DW){1'b1}}, {(DOUT_DW - 1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] c_one = {{ACC_WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------- decode
  logic signed [DIN_DW-1:0] w_din [CPF];
  logic signed [WW-1:0]     w_wt  [KPF][CPF];
  logic [5:0]               w_shift;

  always_comb begin
    for (int c = 0; c < CPF; c++) begin
      w_din[c] = bus.op_din[c*DIN_DW +: DIN_DW];
    end
    for (int k = 0; k < KPF; k++) begin
      for (int c = 0; c < CPF; c++) begin
        w_wt[k][c] = bus.op_weight[(k*CPF + c)*WW +: WW];
      end
    end
    w_shift = (bus.cfg_shift > c_shift_max) ? c_shift_max : bus.cfg_shift;
  end

  // ---------------------------------------------------------------- S1
  logic                     r_first;
  logic                     r_open;
  logic                     r_s1_vld;
  logic                     r_s1_eop;
  logic                     r_s1_first;
  logic                     r_s1_relu;
  logic [5:0]               r_s1_shift;
  logic [KPF*BIAS_DW-1:0]   r_s1_bias;
  logic signed [c_pw-1:0]   r_s1_prod [KPF][CPF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first    <= 1'b1;
      r_open     <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_relu  <= 1'b0;
      r_s1_shift <= '0;
      r_s1_bias  <= '0;
      for (int k = 0; k < KPF; k++) begin
        for (int c = 0; c < CPF; c++) begin
          r_s1_prod[k][c] <= '0;
        end
      end
    end else begin
      r_s1_vld <= bus.op_din_en;
      if (bus.op_din_en) begin
        // An accepted eop makes the following beat the start of a new packet
        r_first    <= bus.op_din_eop;
        r_open     <= ~bus.op_din_eop;
        r_s1_eop   <= bus.op_din_eop;
        r_s1_first <= r_first;
        r_s1_relu  <= bus.cfg_relu;
        r_s1_shift <= w_shift;
        r_s1_bias  <= bus.op_bias;
        for (int k = 0; k < KPF; k++) begin
          for (int c = 0; c < CPF; c++) begin
            r_s1_prod[k][c] <= c_pw'(w_din[c]) * c_pw'(w_wt[k][c]);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic                        r_s2_vld;
  logic                        r_s2_eop;
  logic                        r_s2_first;
  logic                        r_s2_relu;
  logic [5:0]                  r_s2_shift;
  logic [KPF*BIAS_DW-1:0]      r_s2_bias;
  logic signed [ACC_WIDTH-1:0] r_s2_sum [KPF];
  logic signed [ACC_WIDTH-1:0] w_sum    [KPF];

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      w_sum[k] = '0;
      for (int c = 0; c < CPF; c++) begin
        w_sum[k] = w_sum[k] + ACC_WIDTH'(r_s1_prod[k][c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_vld   <= 1'b0;
      r_s2_eop   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_relu  <= 1'b0;
      r_s2_shift <= '0;
      r_s2_bias  <= '0;
      for (int k = 0; k < KPF; k++) r_s2_sum[k] <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_eop   <= r_s1_eop;
        r_s2_first <= r_s1_first;
        r_s2_relu  <= r_s1_relu;
        r_s2_shift <= r_s1_shift;
        r_s2_bias  <= r_s1_bias;
        for (int k = 0; k < KPF; k++) r_s2_sum[k] <= w_sum[k];
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic                        r_s3_vld;
  logic                        r_s3_eop;
  logic                        r_s3_relu;
  logic [5:0]                  r_s3_shift;
  logic signed [ACC_WIDTH-1:0] r_acc      [KPF];
  logic signed [ACC_WIDTH-1:0] w_bias_ext [KPF];

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      w_bias_ext[k] = ACC_WIDTH'($signed(r_s2_bias[k*BIAS_DW +: BIAS_DW])) <<< BIAS_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s3_vld   <= 1'b0;
      r_s3_eop   <= 1'b0;
      r_s3_relu  <= 1'b0;
      r_s3_shift <= '0;
      for (int k = 0; k < KPF; k++) r_acc[k] <= '0;
    end else begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_eop <= r_s2_eop;
        // Packet config is latched from its first beat only
        if (r_s2_first) begin
          r_s3_relu  <= r_s2_relu;
          r_s3_shift <= r_s2_shift;
        end
        for (int k = 0; k < KPF; k++) begin
          r_acc[k] <= r_s2_first ? (r_s2_sum[k] + w_bias_ext[k]) : (r_acc[k] + r_s2_sum[k]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- S4
  logic                       w_fire;
  logic signed [ACC_WIDTH:0]  w_rnd [KPF];
  logic [KPF*DOUT_DW-1:0]     w_res;
  logic [15:0]                w_nsat;
  logic [16:0]                w_sat_sum;
  logic                       r_dout_en;
  logic [KPF*DOUT_DW-1:0]     r_dout;
  logic [15:0]                r_sat_cnt;

  always_comb begin
    w_fire = r_s3_vld & r_s3_eop;
    w_res  = '0;
    w_nsat = '0;
    for (int k = 0; k < KPF; k++) begin
      // One guard bit keeps the rounding add from wrapping
      w_rnd[k] = {r_acc[k][ACC_WIDTH-1], r_acc[k]};
      if (r_s3_shift != 6'd0) begin
        w_rnd[k] = (w_rnd[k] + (c_one <<< (r_s3_shift - 6'd1))) >>> r_s3_shift;
      end
      if (r_s3_relu && w_rnd[k][ACC_WIDTH]) begin
        w_rnd[k] = '0;
      end
      if (w_rnd[k] > c_max) begin
        w_rnd[k] = c_max;
        w_nsat   = w_nsat + 16'd1;
      end else if (w_rnd[k] < c_min) begin
        w_rnd[k] = c_min;
        w_nsat   = w_nsat + 16'd1;
      end
      w_res[k*DOUT_DW +: DOUT_DW] = w_rnd[k][DOUT_DW-1:0];
    end
    w_sat_sum = {1'b0, r_sat_cnt} + {1'b0, w_nsat};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout_en <= 1'b0;
      r_dout    <= '0;
      r_sat_cnt <= '0;
    end else begin
      r_dout_en <= w_fire;
      if (w_fire) begin
        r_dout    <= w_res;
        r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
      end
    end
  end

  assign bus.op_dout_en = r_dout_en;
  assign bus.op_dout    = r_dout;
  assign bus.sat_cnt    = r_sat_cnt;
  assign bus.busy       = r_open | r_s1_vld | r_s2_vld | r_s3_vld;

endmodule

`default_nettype wire

// File: tb/tb_conv_mac_array.sv
// ============================================================================
// tb_conv_mac_array : vector table plus multi-beat sequences for conv_mac_array
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_conv_mac_array;
  localparam int CPF = 4, KPF = 2, DIN_DW = 16, WW = 8, BIAS_DW = 8, DOUT_DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_mac_array_if #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW),
                      .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW)) bus ();

  conv_mac_array #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW),
                   .BIAS_SHIFT(0), .ACC_WIDTH(40), .DOUT_DW(DOUT_DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int l0; int l1;} res_t;
  res_t rq[$];
  always @(negedge clk) begin
    if (bus.op_dout_en === 1'b1)
      rq.push_back('{cyc, int'($signed(bus.op_dout[15:0])), int'($signed(bus.op_dout[31:16]))});
  end

  typedef struct {
    int din[4]; int w0; int w1; int b0; int b1; int sh; bit relu; int e0; int e1; int es;
  } vec_t;
  vec_t vt[10];

  int checks = 0;
  int errors = 0;
  int exp_sat = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic beat(input int d0, d1, d2, d3, input int wa, wb, ba, bb, sh,
                      input bit relu, input bit eop, output int stamp);
    bus.op_din_en  = 1'b1;
    bus.op_din_eop = eop;
    bus.op_din     = {16'(d3), 16'(d2), 16'(d1), 16'(d0)};
    bus.op_weight  = {8'(wb), 8'(wb), 8'(wb), 8'(wb), 8'(wa), 8'(wa), 8'(wa), 8'(wa)};
    bus.op_bias    = {8'(bb), 8'(ba)};
    bus.cfg_shift  = 6'(sh);
    bus.cfg_relu   = relu;
    stamp = cyc;
    @(negedge clk);
  endtask

  // Idle cycles drive eop high with en low: it must be ignored
  task automatic idle();
    bus.op_din_en  = 1'b0;
    bus.op_din_eop = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_results(input int n, input int budget, input string nm);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({nm, " strobe count"}, rq.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    res_t r;
    int   st;
    int   sts[8];

    vt[0] = '{'{1, 2, 3, 4},               1,   -1,    0,  5,  0, 1'b0,     10,     -5, 0};
    vt[1] = '{'{-3, 0, 0, 0},              1,    1,    0,  0,  1, 1'b0,     -1,     -1, 0};
    vt[2] = '{'{-3, 0, 0, 0},              1,    1,    0,  0,  1, 1'b1,      0,      0, 0};
    vt[3] = '{'{5, 0, 0, 0},               1,   -1,    0,  0,  1, 1'b0,      3,     -2, 0};
    vt[4] = '{'{32767, 32767, 32767, 32767}, 127, -128, 0,  0, 63, 1'b0,      0,      0, 0};
    vt[5] = '{'{32767, 32767, 32767, 32767}, 127, -128, 0,  0,  0, 1'b0,  32767, -32768, 2};
    vt[6] = '{'{10, 0, 0, 0},              1,    2,  -20, -3,  0, 1'b1,      0,     17, 0};
    vt[7] = '{'{100, -50, 0, 0},           3,   -2,    7, -1,  4, 1'b0,     10,     -6, 0};
    vt[8] = '{'{-32768, 0, 0, 0},          1,   -1,    0,  0,  0, 1'b0, -32768,  32767, 1};
    vt[9] = '{'{-32768, 0, 0, 0},        127,   -1,    0,  0,  0, 1'b1,      0,  32767, 1};

    bus.op_din_en = 1'b0; bus.op_din_eop = 1'b0; bus.op_din = '0; bus.op_weight = '0;
    bus.op_bias = '0; bus.cfg_shift = '0; bus.cfg_relu = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dout_en", int'(bus.op_dout_en), 0);
    chk("reset dout", int'(bus.op_dout), 0);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset sat_cnt", int'(bus.sat_cnt), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      beat(vt[i].din[0], vt[i].din[1], vt[i].din[2], vt[i].din[3], vt[i].w0, vt[i].w1,
           vt[i].b0, vt[i].b1, vt[i].sh, vt[i].relu, 1'b1, st);
      idle();
      wait_results(1, 12, $sformatf("vec%0d", i));
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk($sformatf("vec%0d latency", i), r.cyc - st, 4);
        chk($sformatf("vec%0d lane0", i), r.l0, vt[i].e0);
        chk($sformatf("vec%0d lane1", i), r.l1, vt[i].e1);
      end
      exp_sat += vt[i].es;
      chk($sformatf("vec%0d sat_cnt", i), int'(bus.sat_cnt), exp_sat);
      chk($sformatf("vec%0d busy after", i), int'(bus.busy), 0);
    end

    // 3-beat packet with gaps; config changes after the first beat must not apply
    beat(1, 1, 1, 1, 2, 2, 0, 0, 0, 1'b0, 1'b0, st);
    chk("gap busy b1", int'(bus.busy), 1);
    idle(); chk("gap busy i1", int'(bus.busy), 1);
    idle(); chk("gap busy i2", int'(bus.busy), 1);
    beat(1, 1, 1, 1, 2, 2, 50, 50, 3, 1'b1, 1'b0, st);
    chk("gap busy b2", int'(bus.busy), 1);
    idle(); chk("gap busy i3", int'(bus.busy), 1);
    idle(); chk("gap busy i4", int'(bus.busy), 1);
    beat(1, 1, 1, 1, 2, 2, 50, 50, 3, 1'b1, 1'b1, st);
    chk("gap busy b3", int'(bus.busy), 1);
    idle();
    wait_results(1, 12, "gap");
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk("gap latency", r.cyc - st, 4);
      chk("gap lane0", r.l0, 24);
      chk("gap lane1", r.l1, 24);
    end
    chk("gap busy end", int'(bus.busy), 0);
    repeat (6) idle();
    chk("gap single strobe", rq.size(), 0);

    // 4-beat saturation, positive then negative
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 4; b++) begin
        beat(32767, 32767, 32767, 32767, (p == 0) ? 127 : -127, (p == 0) ? 127 : -127,
             0, 0, 0, 1'b0, b == 3, st);
      end
      idle();
      wait_results(1, 12, $sformatf("sat%0d", p));
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk($sformatf("sat%0d lane0", p), r.l0, (p == 0) ? 32767 : -32768);
        chk($sformatf("sat%0d lane1", p), r.l1, (p == 0) ? 32767 : -32768);
      end
      exp_sat += 2;
      chk($sformatf("sat%0d sat_cnt", p), int'(bus.sat_cnt), exp_sat);
    end

    // 8 back-to-back single-beat packets
    for (int n = 0; n < 8; n++) begin
      beat(n, 0, 0, 0, 1, 1, 0, 0, 0, 1'b0, 1'b1, sts[n]);
      chk($sformatf("b2b busy %0d", n), int'(bus.busy), 1);
    end
    idle();
    wait_results(8, 20, "b2b");
    for (int n = 0; n < 8; n++) begin
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk($sformatf("b2b%0d latency", n), r.cyc - sts[n], 4);
        chk($sformatf("b2b%0d lane0", n), r.l0, n);
        chk($sformatf("b2b%0d lane1", n), r.l1, n);
      end
    end

    // Reset in the middle of a packet discards it
    beat(100, 0, 0, 0, 1, 1, 0, 0, 0, 1'b0, 1'b0, st);
    beat(100, 0, 0, 0, 1, 1, 0, 0, 0, 1'b0, 1'b0, st);
    bus.op_din_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst sat_cnt", int'(bus.sat_cnt), 0);
    chk("midrst dout_en", int'(bus.op_dout_en), 0);
    rst = 1'b1;
    @(negedge clk);
    beat(7, 0, 0, 0, 1, 1, 0, 0, 0, 1'b0, 1'b1, st);
    idle();
    wait_results(1, 12, "midrst");
    if (rq.size() > 0) begin
      r = rq.pop_front();
      chk("midrst latency", r.cyc - st, 4);
      chk("midrst lane0", r.l0, 7);
      chk("midrst lane1", r.l1, 7);
    end
    repeat (8) idle();
    chk("midrst single strobe", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
